// File: rtl/seq_loader_if.sv
// Byte-stream handshake into the sequence loader.
// The source drives data/valid and the loader drives ready.
`timescale 1ns/1ps
interface seq_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/seq_loader.sv
// Stream-to-RAM loader: validates ASCII nucleotides and writes sequence A, then sequence B, into the sequence RAMs.
// Optional `SEQ_LOWERCASE_EN` accepts lowercase a/c/g/t and writes them uppercased.
`timescale 1ns/1ps
module seq_loader #(
  parameter int N   = 128,
  parameter int Bit = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  seq_loader_if.slave      bus,
  output logic [8:0]       din,
  output logic             en_din,
  output logic             we,
  output logic             sel_b,
  output logic [Bit-1:0]   addr_din,
  output logic [Bit:0]     len_a,
  output logic [Bit:0]     len_b,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  // One bit wider than the address so a full RAM (cnt == N) is distinguishable.
  localparam logic [Bit:0] CNT_MAX = (Bit+1)'(N);

  logic [2:0]   state;
  logic [Bit:0] cnt;
  logic [7:0]   folded;
  logic         is_nuc;
  logic         is_cr;
  logic         is_lf;
  logic         accept;

`ifdef SEQ_LOWERCASE_EN
  assign folded = (bus.in_data inside {8'h61, 8'h63, 8'h67, 8'h74}) ? (bus.in_data & 8'hDF)
                                                                   : bus.in_data;
`else
  assign folded = bus.in_data;
`endif

  assign is_nuc = folded inside {8'h41, 8'h43, 8'h47, 8'h54};
  assign is_cr  = (bus.in_data == 8'h0D);
  assign is_lf  = (bus.in_data == 8'h0A);

  assign bus.in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign accept       = bus.in_valid && bus.in_ready;
  assign we           = en_din;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      din      <= '0;
      en_din   <= 1'b0;
      sel_b    <= 1'b0;
      addr_din <= '0;
      len_a    <= '0;
      len_b    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      en_din <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_LOAD_A;
            cnt   <= '0;
            len_a <= '0;
            len_b <= '0;
            sel_b <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (accept) begin
            if (is_nuc) begin
              if (cnt == CNT_MAX) begin
                state <= S_ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end else begin
                en_din   <= 1'b1;
                din      <= {1'b0, folded};
                addr_din <= cnt[Bit-1:0];
                cnt      <= cnt + 1'b1;
              end
            end else if (is_cr) begin
              // Carriage returns from CRLF line endings are dropped silently.
            end else if (is_lf && (cnt != '0)) begin
              if (state == S_LOAD_A) begin
                len_a <= cnt;
                cnt   <= '0;
                sel_b <= 1'b1;
                state <= S_LOAD_B;
              end else begin
                len_b <= cnt;
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              // Empty sequence or an invalid character aborts the load.
              state <= S_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_loader.md
# seq_loader

Stream-to-RAM loader for the Needleman-Wunsch front end. It accepts the two input sequences as ASCII bytes on a valid/ready stream and validates each character. Nucleotides are written through the write ports of the sequence RAMs (A, then B). On completion the loader reports both sequence lengths to the controller. It is the writer for the `din/en_din/we/addr_din` port of the A/B sequence RAMs, which the score matrix and traceback later read.

## Interface
- `N`, 128, capacity of each sequence RAM in characters
- `Bit`, `$clog2(N)`, RAM address width
- `clk` input 1: system clock, all logic on rising edge
- `rst` input 1: reset, synchronous and active-high
- `start` input 1: single-cycle pulse that begins a load
- `in_data` input 8: ASCII byte
- `in_valid` input 1: `in_data` is valid
- `in_ready` output 1: loader can accept a byte; transfer occurs when `in_valid && in_ready`
- `din` output 9: RAM write data, `{1'b0, char}`
- `en_din` output 1: RAM write enable (port enable)
- `we` output 1: RAM write strobe; always equal to `en_din`
- `sel_b` output 1: 0 targets RAM_A, 1 targets RAM_B
- `addr_din` output Bit: RAM write address
- `len_a` output Bit+1: characters written to RAM_A
- `len_b` output Bit+1: characters written to RAM_B
- `busy` output 1: high in LOAD_A or LOAD_B
- `done` output 1: both sequences loaded successfully
- `error` output 1: load aborted

## Operation
- States: IDLE, LOAD_A, LOAD_B, DONE, ERR.
- IDLE: `in_ready`=0. `start` clears `cnt`, `len_a`, `len_b` and enters LOAD_A.
- LOAD_A / LOAD_B: `in_ready`=1. Each accepted byte is classified:
  - Nucleotide A/C/G/T (0x41, 0x43, 0x47, 0x54):
    - If `cnt < N`: write at `addr_din = cnt` to the current RAM, then `cnt++`.
    - If `cnt == N`: go to ERR (overflow); nothing is written.
  - CR (0x0D): ignored; no write, no count.
  - LF (0x0A) terminator:
    - If `cnt == 0`: go to ERR (empty sequence).
    - Else in LOAD_A: latch `len_a = cnt`, clear `cnt`, enter LOAD_B.
    - Else in LOAD_B: latch `len_b = cnt`, enter DONE.
  - Any other byte: go to ERR.
- DONE: `done`=1, `in_ready`=0. Holds until `start` (restart into LOAD_A with cleared lengths) or `rst`.
- ERR: `error`=1, `in_ready`=0. Lengths hold their last latched values; the partial count is not latched. Exits only on `start` (restart) or `rst`.
- `start` in LOAD_A or LOAD_B is ignored.
- `sel_b` is 0 in LOAD_A and 1 in LOAD_B. It holds its value in other states.
- Classification is combinational on `in_data`.
- `cnt` is Bit+1 wide, so `cnt == N` is representable for any N, including N not a power of 2.

## Timing
- Every output is registered except `in_ready`, which decodes the state directly.
- Write latency: for a nucleotide accepted at edge k, `en_din`/`we`/`din`/`addr_din`/`sel_b` are valid during cycle k+1. The RAM captures the write at edge k+2. `en_din` pulses for exactly one cycle per accepted nucleotide.
- Back-to-back bytes are accepted every cycle; throughput is 1 char/clk.
- `len_a` updates and `sel_b` switches to 1 on the edge that accepts the first LF. The last A-write issues with `sel_b`=0, because it is registered a cycle earlier.
- `done` / `error` rise one edge after the terminating or offending byte is accepted. `busy` falls on the same edge.
- Reset values: state IDLE, `in_ready`=0, `din`=0, `en_din`=0, `we`=0, `sel_b`=0, `addr_din`=0, `len_a`=0, `len_b`=0, `busy`=0, `done`=0, `error`=0.
- `rst` mid-load has priority over everything. The next edge gives reset values, and no pending write is issued after it.

## Configuration
- `SEQ_LOWERCASE_EN` defined: lowercase a/c/g/t (0x61, 0x63, 0x67, 0x74) are accepted and written uppercased, e.g. 'g' writes 0x047.
- Not defined: lowercase bytes are invalid and go to ERR.

## Test plan
- N=5, start, stream "CTGAT\nGATTA\n" -> RAM_A 0..4 = 43,54,47,41,54; RAM_B = 47,41,54,54,41; `len_a`=5, `len_b`=5, `done`=1, 10 write pulses.
- N=5, stream "CTGATA" -> ERR on the 6th 'A', no write at addr 5, `error`=1, `len_a`=0.
- Stream "CG\r\n\nx" -> `len_a`=2, then the second LF is an empty B -> ERR; CR produces no write.
- Stream "CX" -> one write (C), then ERR; `in_ready`=0 afterwards; a new `start` restarts cleanly with `len_a`=`len_b`=0.
- `in_valid` toggling 1-0-1 mid-sequence with `rst` pulsed after 3 chars -> all outputs at reset values the next cycle, no further `en_din`.
- Stream "acg\nt\n": with `SEQ_LOWERCASE_EN` -> writes 41,43,47 / 54, `done`=1; without it -> ERR on the first byte.
